// File: rtl/telem_rx_if.sv
// Serial line into telem_rx and the decoded telemetry it presents.
// slave is the receiver side, master the line driver / consumer side.
interface telem_rx_if;
    logic        rx;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
    logic        vld;
    logic        err;
    logic [7:0]  frm_cnt;

    modport master (output rx, input batt, curr, torque, vld, err, frm_cnt);
    modport slave  (input rx, output batt, curr, torque, vld, err, frm_cnt);
endinterface

// File: rtl/telem_rx.sv
// 8N1 UART receiver plus 8-byte telemetry frame parser (AA 55 + three 12-bit readings).
// Outputs update atomically on a complete, well-formed frame.
module telem_rx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic      clk,
    input  logic      rst,
    telem_rx_if.slave bus
);
    localparam logic [11:0] FullDiv = 12'(BAUD_DIV);
    localparam logic [11:0] HalfDiv = 12'(BAUD_DIV / 2);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} bit_state_e;
    typedef enum logic [1:0] {PsHuntAa, PsHunt55, PsData} parse_state_e;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]  fill_q;
    logic        fall;

    bit_state_e  bstate_q, bstate_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        expire, byte_done, frame_err, byte_rdy_q;

    parse_state_e pstate_q, pstate_d;
    logic [2:0]   pidx_q, pidx_d;
    logic         fmt_err, frame_done, store;
    logic [11:0]  sh_batt_q, sh_curr_q;
    logic [3:0]   sh_tq_hi_q;
    logic [11:0]  batt_q, curr_q, torque_q;
    logic [7:0]   frm_cnt_q;
    logic         vld_q, err_q;

    // fill_q blocks edge detection until the synchronizer holds real samples,
    // so a line already low at reset release is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= 2'd0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
        end
    end

    assign fall   = (fill_q == 2'd3) && rx_prev_q && !rx_sync_q;
    assign expire = (cnt_q == 12'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bstate_q   <= StIdle;
            cnt_q      <= 12'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
            byte_rdy_q <= 1'b0;
        end else begin
            bstate_q   <= bstate_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            byte_rdy_q <= byte_done;
        end
    end

    always_comb begin
        bstate_d  = bstate_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        if (bstate_q != StIdle) cnt_d = expire ? FullDiv : cnt_q - 12'd1;
        case (bstate_q)
            StIdle: begin
                if (fall) begin
                    cnt_d    = HalfDiv;
                    bstate_d = StStart;
                end
            end
            StStart: begin
                if (expire) begin
                    if (rx_sync_q) begin
                        bstate_d = StIdle;
                    end else begin
                        bstate_d  = StData;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            StData: begin
                if (expire) begin
                    shreg_d   = {rx_sync_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) bstate_d = StStop;
                end
            end
            StStop: begin
                if (expire) bstate_d = StIdle;
            end
            default: bstate_d = StIdle;
        endcase
    end

    always_comb begin
        byte_done = (bstate_q == StStop) && expire && rx_sync_q;
        frame_err = (bstate_q == StStop) && expire && !rx_sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q <= PsHuntAa;
            pidx_q   <= 3'd0;
        end else begin
            pstate_q <= pstate_d;
            pidx_q   <= pidx_d;
        end
    end

    always_comb begin
        pstate_d = pstate_q;
        pidx_d   = pidx_q;
        if (frame_err) begin
            pstate_d = PsHuntAa;
        end else if (byte_rdy_q) begin
            case (pstate_q)
                PsHuntAa: if (shreg_q == 8'hAA) pstate_d = PsHunt55;
                PsHunt55: begin
                    if (shreg_q == 8'h55) begin
                        pstate_d = PsData;
                        pidx_d   = 3'd0;
                    end else if (shreg_q != 8'hAA) begin
                        pstate_d = PsHuntAa;
                    end
                end
                PsData: begin
                    if ((!pidx_q[0] && shreg_q[7:4] != 4'h0) || pidx_q == 3'd5) begin
                        pstate_d = PsHuntAa;
                    end else begin
                        pidx_d = pidx_q + 3'd1;
                    end
                end
                default: pstate_d = PsHuntAa;
            endcase
        end
    end

    always_comb begin
        fmt_err    = byte_rdy_q && (pstate_q == PsData) && !pidx_q[0] && (shreg_q[7:4] != 4'h0);
        frame_done = byte_rdy_q && (pstate_q == PsData) && (pidx_q == 3'd5);
        store      = byte_rdy_q && (pstate_q == PsData) && !fmt_err;
    end

    // Torque low byte is taken straight from the shift register on the final byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_batt_q  <= 12'd0;
            sh_curr_q  <= 12'd0;
            sh_tq_hi_q <= 4'd0;
            batt_q     <= 12'd0;
            curr_q     <= 12'd0;
            torque_q   <= 12'd0;
            frm_cnt_q  <= 8'd0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vld_q <= frame_done;
            err_q <= frame_err | fmt_err;
            if (store) begin
                case (pidx_q)
                    3'd0:    sh_batt_q[11:8] <= shreg_q[3:0];
                    3'd1:    sh_batt_q[7:0]  <= shreg_q;
                    3'd2:    sh_curr_q[11:8] <= shreg_q[3:0];
                    3'd3:    sh_curr_q[7:0]  <= shreg_q;
                    3'd4:    sh_tq_hi_q      <= shreg_q[3:0];
                    default: ;
                endcase
            end
            if (frame_done) begin
                batt_q    <= sh_batt_q;
                curr_q    <= sh_curr_q;
                torque_q  <= {sh_tq_hi_q, shreg_q};
                frm_cnt_q <= frm_cnt_q + 8'd1;
            end
        end
    end

    assign bus.batt    = batt_q;
    assign bus.curr    = curr_q;
    assign bus.torque  = torque_q;
    assign bus.vld     = vld_q;
    assign bus.err     = err_q;
    assign bus.frm_cnt = frm_cnt_q;
endmodule

// File: tb/tb_telem_rx.sv
// Directed-plus-random bench for telem_rx: serial driver, queue-based frame model,
// pulse counters, immediate-assertion checks.
module tb_telem_rx;
    localparam int unsigned BD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    telem_rx_if bus ();

    telem_rx #(.BAUD_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int obs_vld = 0;
    int obs_err = 0;
    int obs_both = 0;
    int exp_vld = 0;
    int exp_err = 0;
    logic [11:0] exp_batt = 12'd0;
    logic [11:0] exp_curr = 12'd0;
    logic [11:0] exp_torque = 12'd0;
    logic [7:0]  exp_frm = 8'd0;
    logic [7:0]  win[$];

    always @(negedge clk) begin
        if (bus.vld) obs_vld++;
        if (bus.err) obs_err++;
        if (bus.vld && bus.err) obs_both++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Frame model: bytes since the last resync are kept in win; a frame is
    // AA 55 followed by six bytes whose high-nibble bytes have a zero top nibble.
    function automatic void mdl_byte(input logic [7:0] b, input bit stop_ok);
        logic [7:0] b2, b3, b4, b5, b6;
        if (!stop_ok) begin
            exp_err++;
            win.delete();
            return;
        end
        win.push_back(b);
        if (win.size() == 1) begin
            if (b != 8'hAA) win.delete();
        end else if (win.size() == 2) begin
            if (b == 8'hAA) begin
                win.delete();
                win.push_back(8'hAA);
            end else if (b != 8'h55) begin
                win.delete();
            end
        end else if ((win.size() % 2 == 1) && (b[7:4] != 4'h0)) begin
            exp_err++;
            win.delete();
        end else if (win.size() == 8) begin
            b2 = win[2]; b3 = win[3]; b4 = win[4]; b5 = win[5]; b6 = win[6];
            exp_batt   = {b2[3:0], b3};
            exp_curr   = {b4[3:0], b5};
            exp_torque = {b6[3:0], b};
            exp_vld++;
            exp_frm++;
            win.delete();
        end
    endfunction

    function automatic void mdl_reset();
        win.delete();
        exp_batt   = 12'd0;
        exp_curr   = 12'd0;
        exp_torque = 12'd0;
        exp_frm    = 8'd0;
    endfunction

    // With do_rst, rst is pulsed mid start bit and the byte is not modelled.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit do_rst);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            if (do_rst && i == 0) begin
                wait_cyc(BD / 2);
                rst = 1'b1;
                wait_cyc(1);
                rst = 1'b0;
                mdl_reset();
                chk("rst_batt", 32'(bus.batt), 32'(exp_batt));
                chk("rst_curr", 32'(bus.curr), 32'(exp_curr));
                chk("rst_torque", 32'(bus.torque), 32'(exp_torque));
                chk("rst_frm_cnt", 32'(bus.frm_cnt), 32'(exp_frm));
                wait_cyc(BD - BD / 2 - 1);
            end else begin
                wait_cyc(BD);
            end
        end
        bus.rx = 1'b1;
        if (!do_rst) mdl_byte(b, stop_ok);
    endtask

    task automatic send_gap();
        wait_cyc($urandom_range(0, 3));
    endtask

    task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                              input bit gaps);
        logic [7:0] fr[8];
        fr = '{8'hAA, 8'h55, {4'h0, b[11:8]}, b[7:0], {4'h0, c[11:8]}, c[7:0],
               {4'h0, t[11:8]}, t[7:0]};
        for (int i = 0; i < 8; i++) begin
            send_byte(fr[i], 1'b1, 1'b0);
            if (gaps) send_gap();
        end
    endtask

    task automatic send_list(input logic [7:0] bytes[$], input int bad_stop_idx);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (i != bad_stop_idx), 1'b0);
            send_gap();
        end
    endtask

    task automatic checkpoint(input string tag);
        wait_cyc(4);
        chk({tag, "_vld_cnt"}, 32'(obs_vld), 32'(exp_vld));
        chk({tag, "_err_cnt"}, 32'(obs_err), 32'(exp_err));
        chk({tag, "_batt"}, 32'(bus.batt), 32'(exp_batt));
        chk({tag, "_curr"}, 32'(bus.curr), 32'(exp_curr));
        chk({tag, "_torque"}, 32'(bus.torque), 32'(exp_torque));
        chk({tag, "_frm_cnt"}, 32'(bus.frm_cnt), 32'(exp_frm));
    endtask

    function automatic logic [11:0] rnd12();
        return 12'($urandom_range(0, 4095));
    endfunction

    initial begin
        logic [7:0] q[$];
        int vld_base;

        bus.rx = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        chk("reset_vld", 32'(bus.vld), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        checkpoint("reset");

        send_frame(12'hABC, 12'h123, 12'hFFF, 1'b1);
        checkpoint("frame1");
        chk("frame1_batt_const", 32'(bus.batt), 32'h0ABC);
        chk("frame1_frm_const", 32'(bus.frm_cnt), 32'd1);

        q = '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07};
        send_list(q, -1);
        checkpoint("garbage");

        q = '{8'hAA, 8'h55, 8'h1A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
        send_list(q, -1);
        checkpoint("fmt_err");
        send_frame(rnd12(), rnd12(), rnd12(), 1'b1);
        checkpoint("after_fmt");

        q = '{8'hAA, 8'h55, 8'h03, 8'h44, 8'h05, 8'h66, 8'h07, 8'h88};
        send_list(q, 4);
        checkpoint("stop_err");
        send_frame(rnd12(), rnd12(), rnd12(), 1'b1);
        checkpoint("after_stop");

        for (int n = 0; n < 4; n++) begin
            send_frame(rnd12(), rnd12(), rnd12(), 1'b1);
            checkpoint("rand");
        end

        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte({4'h0, 4'($urandom_range(0, 15))}, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b1);
        q = '{8'h02, 8'($urandom_range(0, 255)), 8'h09, 8'($urandom_range(0, 255))};
        send_list(q, -1);
        checkpoint("mid_rst");
        send_frame(rnd12(), rnd12(), rnd12(), 1'b1);
        checkpoint("post_rst");

        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        mdl_reset();
        wait_cyc(5);
        bus.rx = 1'b0;
        wait_cyc(BD / 4);
        bus.rx = 1'b1;
        wait_cyc(3 * BD);
        checkpoint("glitch");

        vld_base = obs_vld;
        for (int n = 0; n < 256; n++) send_frame(rnd12(), rnd12(), rnd12(), 1'b0);
        checkpoint("wrap");
        chk("wrap_frm_zero", 32'(bus.frm_cnt), 32'd0);
        chk("wrap_vld_256", 32'(obs_vld - vld_base), 32'd256);
        chk("vld_err_overlap", 32'(obs_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/telem_rx.md
# telem_rx

Serial telemetry receiver and frame decoder that consumes the `TX` line driven by the eBike controller. It recovers the 8N1 UART byte stream, locks onto the 8-byte telemetry frame, and presents the latest battery, current and torque readings as registered 12-bit words with a one-cycle valid strobe. It sits outside the controller: on the bench harness and in the display/logging path, with `RX` tied to the controller's `TX`.

## Interface
- `BAUD_DIV`, 2604: clocks per bit (50 MHz / 19200 baud); legal range 16..4095.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `RX`  in  1  serial input, idle high, asynchronous to `clk`.
- `batt`  out  12  last decoded battery reading.
- `curr`  out  12  last decoded current reading.
- `torque`  out  12  last decoded torque reading.
- `vld`  out  1  one-cycle pulse; `batt`/`curr`/`torque` updated this cycle.
- `err`  out  1  one-cycle pulse on framing or format error.
- `frm_cnt`  out  8  count of good frames, wraps 255->0.

## Operation
- Frame: 8 bytes, LSB-first 8N1 each: `0xAA`, `0x55`, `{4'h0,batt[11:8]}`, `batt[7:0]`, `{4'h0,curr[11:8]}`, `curr[7:0]`, `{4'h0,torque[11:8]}`, `torque[7:0]`.
- `RX` passes through a 2-flop synchronizer; its input flops reset to 1.
- Bit engine states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on the synchronized `RX` loads the baud counter with `BAUD_DIV/2` (integer) and enters START.
  - START: at count expiry, sample `RX`. If high (false start), return to IDLE with no error. If low, reload `BAUD_DIV` and enter DATA.
  - DATA: sample at each expiry and shift right into an 8-bit register. After the 8th sample, enter STOP.
  - STOP: sample at expiry. If 1, pulse internal `byte_rdy` the next cycle. If 0, pulse `err`, discard the byte and force the parser to HUNT_AA. Then return to IDLE.
  - A new start edge is accepted immediately after STOP; no idle gap is required.
- Parser states: HUNT_AA, HUNT_55, DATA with a 3-bit index 0..5. The parser acts only on `byte_rdy`.
  - HUNT_AA: on `0xAA` go to HUNT_55; on any other byte stay.
  - HUNT_55: on `0x55` go to DATA with index 0; on `0xAA` stay in HUNT_55; on any other byte go to HUNT_AA.
  - DATA, even index (high-nibble byte): if `byte[7:4]!=0`, pulse `err` and go to HUNT_AA. Otherwise store the nibble in a shadow register.
  - DATA, odd index: store the low byte in a shadow register.
  - At index 5: load all three outputs from the shadow registers simultaneously, pulse `vld`, increment `frm_cnt`, and go to HUNT_AA.
- Outputs are never partially updated; an aborted frame leaves `batt`/`curr`/`torque` unchanged.
- `err` and `vld` never assert in the same cycle.

## Timing
- Reset values:
  - `batt`, `curr`, `torque`, `frm_cnt`: 0.
  - `vld`, `err`: 0.
  - Bit engine: IDLE. Parser: HUNT_AA.
- `rst` mid-byte or mid-frame: the partial byte and frame are dropped, outputs return to reset values, and the next cycle is IDLE/HUNT_AA.
  - If `RX` is low when `rst` deasserts, no start is detected until a new falling edge.
- Sampling latency: the synchronizer adds 2 cycles. The mid-bit sample occurs `BAUD_DIV/2 + k*BAUD_DIV` cycles after the synchronized falling edge, for k = 0..9.
- `byte_rdy` is high on the cycle after the stop-bit sample edge.
- `vld` and `err` are registered and go high on the cycle after the corresponding `byte_rdy`, or after the stop-sample edge for a framing error. Each is high for exactly 1 cycle.
- Baud counter: 12-bit down-counter; expiry is count==1, and it reloads on the same edge.
- No backpressure: a consumer that misses `vld` simply reads the held values later.

## Test plan
- Reset, then send frame AA 55 0A BC 01 23 0F FF with `BAUD_DIV`=16 -> one `vld` pulse; `batt`=0xABC, `curr`=0x123, `torque`=0xFFF, `frm_cnt`=1, `err` never high.
- Leading garbage 13 AA AA 55 then 6 payload bytes (00 05 00 06 00 07) -> exactly one `vld`; outputs 0x005/0x006/0x007.
- Third byte 0x1A -> `err` pulse, no `vld`, outputs hold previous frame values; an immediately following good frame decodes normally.
- Stop bit forced 0 on the 5th byte -> `err` pulse, parser resynchronizes, no `vld` for that frame; the next frame is good.
- 0.25-bit low glitch on idle `RX` -> no byte, no `err`; then 256 good frames -> `frm_cnt` wraps to 0 with 256 `vld` pulses.
- Assert `rst` during the 4th byte of a frame -> outputs 0 next cycle; the remaining bytes produce no `vld`; the next full frame produces `vld`.
